// File: rtl/rf_pkg.sv
// Shared register-file definitions for the writeback path.
// Provides register geometry, writeback source indices and the register address type.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  // Writeback requester indices
  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_LSU = 1;
  localparam int unsigned SRC_MUL = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the execute/memory units and the arbiter.
//   req_valid : per-source writeback request
//   req_ready : per-source grant (valid & ready = transfer)
//   req_addr  : packed destination addresses, source i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   req_data  : packed writeback data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
// Modports: master = requesting units, slave = arbiter.
interface regfile_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned ADDRESS_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH    = REG_DATA_W
);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps modulo NUM_REQ;
// the pointer itself is held by the parent.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   gnt       : one-hot grant (all zero when nothing requests)
//   gnt_idx   : index of the granted requester
//   gnt_valid : a grant was issued
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    gnt_idx,
  output logic               gnt_valid
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(idx);
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with a destination
// scoreboard for RAW hazard detection at decode.
// Optional feature macro: WB_BYPASS_EN (forward the committing write to decode and
// drop the stall for the register being committed).
//   clk, rst            : clock, asynchronous active-high reset
//   wb                  : writeback request bus (slave side)
//   issue_valid/addr    : decode reserves a destination
//   rs1_addr, rs2_addr  : decode source operands
//   stall               : RAW hazard on rs1 or rs2
//   fwd1_*/fwd2_*       : bypass hit and data (zero unless WB_BYPASS_EN)
//   WE3, AD3, WD3       : register file write port
//   busy_mask           : scoreboard state
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned ADDRESS_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH    = REG_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  regfile_wb_arbiter_if.slave           wb,
  input  logic                          issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]      issue_addr,
  input  logic [ADDRESS_WIDTH-1:0]      rs1_addr,
  input  logic [ADDRESS_WIDTH-1:0]      rs2_addr,
  output logic                          stall,
  output logic                          fwd1_valid,
  output logic                          fwd2_valid,
  output logic [DATA_WIDTH-1:0]         fwd1_data,
  output logic [DATA_WIDTH-1:0]         fwd2_data,
  output logic                          WE3,
  output logic [ADDRESS_WIDTH-1:0]      AD3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic [2**ADDRESS_WIDTH-1:0]   busy_mask
);

  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NumRegs = 2 ** ADDRESS_WIDTH;

  logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]       gnt;
  logic [IdxW-1:0]          gnt_idx;
  logic                     gnt_valid;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;

  logic                     we3_q;
  logic [ADDRESS_WIDTH-1:0] ad3_q;
  logic [DATA_WIDTH-1:0]    wd3_q;
  logic [NumRegs-1:0]       busy_q, busy_d;

  logic                     hazard1, hazard2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (wb.req_valid),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Grants are masked while reset is held so nothing appears to transfer.
  assign wb.req_ready = rst ? '0 : gnt;

  assign sel_addr = wb.req_addr[32'(gnt_idx) * ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_data = wb.req_data[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      rr_ptr_d = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  // Scoreboard next state: commit clears, issue sets afterwards so the newer
  // reservation wins a same-cycle collision.
  always_comb begin
    busy_d = busy_q;
    if (we3_q) begin
      busy_d[ad3_q] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      ad3_q    <= '0;
      wd3_q    <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      we3_q    <= 1'b0;
      // x0 grants are consumed but never reach the register file.
      if (gnt_valid && (sel_addr != '0)) begin
        we3_q <= 1'b1;
        ad3_q <= sel_addr;
        wd3_q <= sel_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic commit_hide;

  // The committing register is no longer a hazard unless decode re-reserves it now.
  assign commit_hide = we3_q && !(issue_valid && (issue_addr == ad3_q));

  assign hazard1 = busy_q[rs1_addr] && (rs1_addr != '0) &&
                   !(commit_hide && (ad3_q == rs1_addr));
  assign hazard2 = busy_q[rs2_addr] && (rs2_addr != '0) &&
                   !(commit_hide && (ad3_q == rs2_addr));

  assign fwd1_valid = we3_q && (ad3_q == rs1_addr) && (rs1_addr != '0);
  assign fwd2_valid = we3_q && (ad3_q == rs2_addr) && (rs2_addr != '0);
  assign fwd1_data  = wd3_q;
  assign fwd2_data  = wd3_q;
`else
  assign hazard1 = busy_q[rs1_addr] && (rs1_addr != '0);
  assign hazard2 = busy_q[rs2_addr] && (rs2_addr != '0);

  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
`endif

  assign stall     = hazard1 || hazard2;
  assign WE3       = we3_q;
  assign AD3       = ad3_q;
  assign WD3       = wd3_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Expected writes are queued when a grant is
// expected and popped at the following clock edge.
module tb_regfile_wb_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [AW-1:0] issue_addr, rs1_addr, rs2_addr;
  logic          stall, fwd1_valid, fwd2_valid;
  logic [DW-1:0] fwd1_data, fwd2_data;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;
  logic [31:0]   busy_mask;

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter_if #(
    .NUM_REQ       (NR),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) wb_if ();

  regfile_wb_arbiter #(
    .NUM_REQ       (NR),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb_if),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .stall       (stall),
    .fwd1_valid  (fwd1_valid),
    .fwd2_valid  (fwd2_valid),
    .fwd1_data   (fwd1_data),
    .fwd2_data   (fwd2_data),
    .WE3         (WE3),
    .AD3         (AD3),
    .WD3         (WD3),
    .busy_mask   (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    wb_if.req_valid[s]         = v;
    wb_if.req_addr[s*AW +: AW] = a;
    wb_if.req_data[s*DW +: DW] = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Advance one clock; a queued write must appear now, otherwise WE3 must be low.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("we3_write", WE3, 1'b1);
      check("ad3", AD3, e.a);
      check("wd3", WD3, e.d);
    end else begin
      check("we3_idle", WE3, 1'b0);
    end
  endtask

  initial begin
    rst             = 1'b1;
    issue_valid     = 1'b0;
    issue_addr      = '0;
    rs1_addr        = '0;
    rs2_addr        = '0;
    wb_if.req_valid = '1;
    wb_if.req_addr  = '0;
    wb_if.req_data  = '0;

    // Reset state
    #1;
    check("rst_we3", WE3, 1'b0);
    check("rst_ad3", AD3, 5'd0);
    check("rst_wd3", WD3, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_ready", wb_if.req_ready, 3'b000);
    wb_if.req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset mid-write
    issue_valid = 1'b1;
    issue_addr  = 5'd5;
    tick();
    issue_valid = 1'b0;
    check("midrst_busy_pre", busy_mask, 32'h0000_0020);
    set_req(0, 1'b1, 5'd5, 32'hDEAD);
    #1;
    check("midrst_ready", wb_if.req_ready, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_we3", WE3, 1'b0);
    check("midrst_busy", busy_mask, 32'd0);
    check("midrst_ready_rst", wb_if.req_ready, 3'b000);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;

    // Single write
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("single_busy_set", busy_mask, 32'h0000_0080);
    set_req(1, 1'b1, 5'd7, 32'h1234);
    #1;
    check("single_ready", wb_if.req_ready, 3'b010);
    push(5'd7, 32'h1234);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    #1;
    check("single_busy_commit", busy_mask, 32'h0000_0080);
    tick();
    check("single_busy_clear", busy_mask, 32'd0);

    // Lone request on source 2 moves the pointer back to 0
    set_req(2, 1'b1, 5'd10, 32'hA0A0);
    #1;
    check("lone2_ready", wb_if.req_ready, 3'b100);
    push(5'd10, 32'hA0A0);
    tick();
    set_req(2, 1'b0, 5'd0, 32'd0);

    // Three-way contention: grants 0,1,2 then back to 0
    set_req(0, 1'b1, 5'd1, 32'hA1);
    set_req(1, 1'b1, 5'd2, 32'hA2);
    set_req(2, 1'b1, 5'd3, 32'hA3);
    #1;
    check("rr_g0", wb_if.req_ready, 3'b001);
    push(5'd1, 32'hA1);
    tick();
    check("rr_g1", wb_if.req_ready, 3'b010);
    push(5'd2, 32'hA2);
    tick();
    check("rr_g2", wb_if.req_ready, 3'b100);
    push(5'd3, 32'hA3);
    tick();
    set_req(2, 1'b0, 5'd0, 32'd0);
    set_req(0, 1'b1, 5'd11, 32'hB1);
    set_req(1, 1'b1, 5'd12, 32'hB2);
    #1;
    check("rr_wrap_g0", wb_if.req_ready, 3'b001);
    push(5'd11, 32'hB1);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0);

    // RAW hazard on x9
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    tick();
    issue_valid = 1'b0;
    check("haz_busy", busy_mask, 32'h0000_0200);
    rs2_addr = 5'd9;
    #1;
    check("haz_stall_rs2", stall, 1'b1);
    rs2_addr = 5'd0;
    rs1_addr = 5'd9;
    #1;
    check("haz_stall_rs1", stall, 1'b1);
    tick();
    check("haz_stall_wait", stall, 1'b1);
    set_req(2, 1'b1, 5'd9, 32'h99);
    #1;
    check("haz_ready", wb_if.req_ready, 3'b100);
    push(5'd9, 32'h99);
    tick();
    set_req(2, 1'b0, 5'd0, 32'd0);
    #1;
`ifdef WB_BYPASS_EN
    check("haz_commit_stall", stall, 1'b0);
    check("haz_fwd1_valid", fwd1_valid, 1'b1);
    check("haz_fwd1_data", fwd1_data, 32'h99);
`else
    check("haz_commit_stall", stall, 1'b1);
    check("haz_fwd1_valid", fwd1_valid, 1'b0);
    check("haz_fwd1_data", fwd1_data, 32'h0);
`endif
    check("haz_fwd2_valid", fwd2_valid, 1'b0);
    tick();
    check("haz_after_stall", stall, 1'b0);
    check("haz_after_busy", busy_mask, 32'd0);
    rs1_addr = 5'd0;

    // Set/clear collision on x4
    issue_valid = 1'b1;
    issue_addr  = 5'd4;
    tick();
    issue_valid = 1'b0;
    check("coll_busy_set", busy_mask, 32'h0000_0010);
    set_req(0, 1'b1, 5'd4, 32'h44);
    #1;
    check("coll_ready", wb_if.req_ready, 3'b001);
    push(5'd4, 32'h44);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b1;
    issue_addr  = 5'd4;
    rs2_addr    = 5'd4;
    #1;
    check("coll_stall", stall, 1'b1);
`ifdef WB_BYPASS_EN
    check("coll_fwd2_valid", fwd2_valid, 1'b1);
`else
    check("coll_fwd2_valid", fwd2_valid, 1'b0);
`endif
    tick();
    issue_valid = 1'b0;
    check("coll_busy_kept", busy_mask, 32'h0000_0010);
    set_req(1, 1'b1, 5'd4, 32'h45);
    #1;
    check("coll2_ready", wb_if.req_ready, 3'b010);
    push(5'd4, 32'h45);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    tick();
    check("coll_busy_clear", busy_mask, 32'd0);
    check("coll_stall_clear", stall, 1'b0);
    rs2_addr = 5'd0;

    // x0 write: granted, never committed, never reserved
    issue_valid = 1'b1;
    issue_addr  = 5'd3;
    tick();
    check("x0_busy_pre", busy_mask, 32'h0000_0008);
    issue_addr = 5'd0;
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("x0_ready", wb_if.req_ready, 3'b010);
    tick();
    issue_valid = 1'b0;
    set_req(1, 1'b0, 5'd0, 32'd0);
    check("x0_busy", busy_mask, 32'h0000_0008);
    rs1_addr = 5'd0;
    #1;
    check("x0_stall", stall, 1'b0);
    tick();
    check("x0_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
